// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues credit-limited requests to a 1-cycle imem,
// buffers returned words in a prefetch FIFO and hands {pc, pc+4, instr} to decode; redirects flush.
module fetch_unit #(
  parameter int                 ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
  parameter int                 FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc4,
  input  logic              redir_valid,
  input  logic [1:0]        redir_mode,
  input  logic [ADDR_W-1:0] redir_pc4,
  input  logic [25:0]       redir_imm,
  input  logic [ADDR_W-1:0] redir_reg,
  output logic              err_misalign
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] WORD_INC   = ADDR_W'(4);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr;
  } entry_t;

  entry_t             mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
  logic               inflight_q, inflight_d;
  logic               kill_q, kill_d;
  logic               err_q, err_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               redir_act;
  logic               credit_ok;
  logic               push;
  logic               pop;
  logic [ADDR_W-1:0]  target;
  entry_t             head;

  always_comb begin
    target = redir_reg;
    unique case (redir_mode)
      2'b01:   target = {redir_pc4[ADDR_W-1:28], redir_imm, 2'b00};
      2'b10:   target = redir_pc4 + {{(ADDR_W-18){redir_imm[15]}}, redir_imm[15:0], 2'b00};
      default: target = redir_reg;
    endcase
  end

  assign redir_act = redir_valid & (redir_mode != 2'b00);
  // Credits count both buffered and outstanding words; a same-cycle pop does not return one.
  assign credit_ok = (count_q + CNT_W'(inflight_q)) < DEPTH_C;
  assign imem_req  = rst_n & fetch_en & ~redir_valid & credit_ok;
  assign imem_addr = fetch_pc_q;

  assign head      = mem[rd_ptr_q];
  assign if_valid  = (count_q != '0);
  assign if_instr  = head.instr;
  assign if_pc     = head.pc;
  assign if_pc4    = head.pc + WORD_INC;
  assign err_misalign = err_q;

  assign push = inflight_q & ~kill_q & ~redir_act;
  assign pop  = if_valid & if_ready & ~redir_act;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = imem_req;
    kill_d     = 1'b0;
    err_d      = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (imem_req) begin
      fetch_pc_d = fetch_pc_q + WORD_INC;
      req_pc_d   = fetch_pc_q;
    end
    if (redir_act) begin
      fetch_pc_d = target & ALIGN_MASK;
      kill_d     = inflight_q;
      err_d      = (target[1:0] != 2'b00);
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      err_q      <= err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: validity is carried entirely by count_q.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= '{pc: req_pc_q, instr: imem_rdata};
  end

endmodule
